// File: rtl/w2_stream_reader.sv
// Read-side sequencer for the layer-2 weight SRAM: sweeps addresses 0..DEPTH-1 on start,
// hides the one-cycle read latency behind a 2-entry skid FIFO and streams words over valid/ready.
module w2_stream_reader #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_q,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [AW-1:0] w_idx,
  output logic          w_last,
  output logic          o_dbg_state
);

  // Handshake: a word transfers on any rising edge where w_valid & w_ready; while
  // w_valid is high and w_ready low, w_data/w_idx/w_last hold their values.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_LAST  = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_acc_cnt;
  logic          r_inflight;
  logic [AW-1:0] r_tag;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_fdata [2];
  logic [AW-1:0] r_fidx  [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_occ;
  logic          r_done;

  logic w_start_acc;
  logic w_pop;
  logic w_push;
  logic w_room;
  logic w_issue;
  logic w_final_pop;

  assign w_valid     = (r_occ != 2'd0);
  assign w_pop       = w_valid & w_ready;
  assign w_push      = r_inflight;
  // A new read may only be issued if it is guaranteed a FIFO slot when it lands.
  assign w_room      = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_start_acc = (r_state == S_IDLE) & start;
  assign w_issue     = (r_state == S_RUN) & (r_rd_ptr < L_DEPTH) & w_room;
  assign w_final_pop = (r_state == S_RUN) & w_pop & (r_acc_cnt == L_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_final_pop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_acc_cnt  <= '0;
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_occ      <= 2'd0;
      r_done     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fdata[i] <= '0;
        r_fidx[i]  <= '0;
      end
    end else begin
      r_done     <= w_final_pop;
      r_inflight <= w_issue;
      if (w_start_acc) begin
        r_rd_ptr  <= '0;
        r_acc_cnt <= '0;
      end else begin
        if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_pop)   r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_issue) begin
        r_addr <= r_rd_ptr[AW-1:0];
        r_tag  <= r_rd_ptr[AW-1:0];
      end
      // SRAM data for the address set on the previous edge is valid this cycle.
      if (w_push) begin
        r_fdata[r_wp] <= sram_q;
        r_fidx[r_wp]  <= r_tag;
        r_wp          <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign sram_we     = 1'b0;
  assign sram_addr   = r_addr;
  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign w_data      = r_fdata[r_rp];
  assign w_idx       = r_fidx[r_rp];
  assign w_last      = w_valid & ({1'b0, r_fidx[r_rp]} == L_LAST);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_w2_stream_reader.sv
// Bench for w2_stream_reader: SRAM model, expected-word queue built from memory contents,
// and a per-cycle compare process for data order, hold-under-stall and done timing.
module tb_w2_stream_reader;

  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_q;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] w_idx;
  logic          w_last;
  logic          dbg_state;

  logic [DW-1:0] mem [16];
  logic [AW+DW:0] exp_q [$];

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;
  int xfer_count = 0;
  int ready_mode = 0;

  w2_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_q(sram_q),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx),
    .w_last(w_last), .o_dbg_state(dbg_state)
  );

  // clock / SRAM model: data for the current address is visible during the cycle
  always #5 clk = ~clk;
  assign sram_q = mem[sram_addr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       w_ready = 1'b1;
      1:       w_ready = 1'($urandom_range(0, 1));
      default: w_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_pass();
    logic [AW+DW:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      e = {(i == DEPTH - 1), AW'(i), mem[i]};
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string name);
    int n = 0;
    while (done_count < target && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'(done_count), 32'(target));
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_single_done"}, 32'(done_count), 32'(target));
  endtask

  task automatic wait_xfers(input int target, input int max_cyc);
    int n = 0;
    while (xfer_count < target && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    chk("xfer_wait", 32'(xfer_count >= target), 32'd1);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  // scoreboard: compare every cycle outputs are meaningful
  logic           exp_done = 1'b0;
  logic           prev_stall = 1'b0;
  logic [DW-1:0]  prev_data;
  logic [AW-1:0]  prev_idx;
  logic [AW+DW:0] cur;

  always @(negedge clk) begin
    chk("sram_we", 32'(sram_we), 32'd0);
    if (rst) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      if (done) begin
        done_count++;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(w_valid), 32'd1);
        chk("hold_data", 32'(w_data), 32'(prev_data));
        chk("hold_idx", 32'(w_idx), 32'(prev_idx));
      end
      exp_done = 1'b0;
      if (w_valid && w_ready) begin
        xfer_count++;
        chk("busy_in_xfer", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got idx %0d data %0h, expected none", w_idx, w_data);
        end else begin
          cur = exp_q.pop_front();
          chk("data", 32'(w_data), 32'(cur[DW-1:0]));
          chk("idx", 32'(w_idx), 32'(cur[AW+DW-1:DW]));
          chk("last", 32'(w_last), 32'(cur[AW+DW]));
          exp_done = cur[AW+DW];
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_idx   = w_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fv;
    int dk;
    int n;
    rst = 1'b1;
    start = 1'b0;
    load_ramp();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // full-rate pass: latency and done timing pinned by hand
    ready_mode = 0;
    push_pass();
    base = done_count;
    pulse_start();
    fv = -1;
    dk = -1;
    for (int k = 0; k < 40 && dk < 0; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_after_start", 32'(busy), 32'd1);
      if (fv < 0 && w_valid) begin
        fv = k;
        chk("first_data", 32'(w_data), 32'h1000);
        chk("first_last", 32'(w_last), 32'd0);
      end
      if (done && dk < 0) dk = k;
    end
    chk("first_valid_latency", 32'(fv), 32'd2);
    chk("done_latency", 32'(dk), 32'd12);
    wait_done(base + 1, 50, "pass_full_rate");

    // backpressure right after the first valid word
    ready_mode = 2;
    repeat (2) @(posedge clk);
    push_pass();
    base = done_count;
    pulse_start();
    n = 0;
    while (!w_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(w_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_data_held", 32'(w_data), 32'h1000);
      chk("bp_addr_held", 32'(sram_addr), 32'd1);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_done(base + 1, 60, "pass_backpressure");

    // random ready with random weights
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    ready_mode = 1;
    push_pass();
    base = done_count;
    pulse_start();
    wait_done(base + 1, 200, "pass_random_ready");

    // start re-pulsed mid-pass must be ignored
    load_ramp();
    ready_mode = 1;
    push_pass();
    base = done_count;
    n = xfer_count;
    pulse_start();
    wait_xfers(n + 4, 100);
    pulse_start();
    chk("busy_after_restart_pulse", 32'(busy), 32'd1);
    wait_done(base + 1, 200, "pass_start_ignored");

    // asynchronous reset mid-pass, then a fresh pass from word 0
    ready_mode = 0;
    push_pass();
    n = xfer_count;
    pulse_start();
    wait_xfers(n + 6, 100);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_valid", 32'(w_valid), 32'd0);
    chk("arst_data", 32'(w_data), 32'd0);
    chk("arst_idx", 32'(w_idx), 32'd0);
    chk("arst_last", 32'(w_last), 32'd0);
    chk("arst_addr", 32'(sram_addr), 32'd0);
    chk("arst_we", 32'(sram_we), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    base = done_count;
    repeat (6) @(negedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_count), 32'(base));
    push_pass();
    pulse_start();
    wait_done(base + 1, 60, "pass_after_reset");

    // start held across done launches back-to-back passes
    ready_mode = 0;
    push_pass();
    push_pass();
    base = done_count;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (done_count < base + 1 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1 start = 1'b0;
    wait_done(base + 2, 60, "pass_back_to_back");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w2_stream_reader.md
# w2_stream_reader

Read-side sequencer for the layer-2 weight SRAM (16-bit words, 4-bit address, one-cycle synchronous read, write/read exclusive on `we`). On `start` it sweeps the SRAM from address 0 to DEPTH-1. It absorbs the SRAM read latency and streams the weights to the downstream MAC over a valid/ready handshake, sustaining one word per cycle when not back-pressured. It sits between the weight SRAM and the layer-2 datapath.

## Interface
Parameters:
- `DEPTH`, 10: number of weight words streamed per pass (1..2^AW).
- `AW`, 4: SRAM address width.
- `DW`, 16: weight word width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only when idle.
- `busy`  out  1  high from the edge accepting `start` until `done`.
- `done`  out  1  one-cycle pulse after the last word handshakes.
- `sram_we`  out  1  SRAM write enable; held 0 at all times, including reset.
- `sram_addr`  out  AW  SRAM address, registered.
- `sram_q`  in  DW  SRAM read data, valid the cycle after the address edge.
- `w_data`  out  DW  weight word presented downstream.
- `w_valid`  out  1  `w_data` valid.
- `w_ready`  in  1  downstream accepts; transfer = `w_valid & w_ready`.
- `w_idx`  out  AW  SRAM address that `w_data` came from.
- `w_last`  out  1  high with the word whose `w_idx` = DEPTH-1.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE + `start`: go to RUN, `busy`=1, `rd_ptr`=0, `acc_cnt`=0. `start` in RUN is ignored.
- Read issue: in RUN, issue read of `rd_ptr` when `rd_ptr` < DEPTH and `occ + inflight - pop` < 2.
  - `occ` is the output buffer occupancy (0..2).
  - `inflight` is a 1-bit flag for an issued read not yet captured.
  - `pop` = `w_valid & w_ready` this cycle.
- On issue: `sram_addr` <= `rd_ptr`, `inflight` <= 1 with tag `rd_ptr`, then `rd_ptr` increments.
- When no read is issued, `sram_addr` holds its value. A harmless re-read is fine because `sram_we`=0.
- Capture: the cycle after the address edge, `inflight`=1, and `sram_q` plus its tag is pushed into the 2-entry FIFO.
- Head of FIFO drives `w_data`, `w_idx`, `w_last`. `w_valid` = (`occ` != 0).
- Push and pop in the same cycle are legal; `occ` is unchanged and order is preserved.
- Words are emitted strictly in address order 0..DEPTH-1, each exactly once.
- `acc_cnt` increments on each pop. The pop with `acc_cnt` = DEPTH-1 causes:
  - `done`=1 for the next cycle;
  - `busy`=0 at the same edge;
  - a return to IDLE, with the FIFO empty.
- `start` asserted in the same cycle as `done` is sampled, because the block is IDLE by then.
- Reset mid-pass: the pass is abandoned, the FIFO and `inflight` are cleared, and no `done` is produced.
- Reset values: `busy`=0, `done`=0, `sram_we`=0, `sram_addr`=0, `w_valid`=0, `w_data`=0, `w_idx`=0, `w_last`=0.
- `w_data` may change only on a pop or when the FIFO goes from empty to non-empty. It must be held stable while `w_valid & !w_ready`.

## Timing
- E0 = edge sampling `start`.
  - E1: `sram_addr`=0 is sampled by the SRAM.
  - After E2: `w_valid`=1, `w_data`=mem[0].
  - Start-to-first-valid latency is 2 cycles.
- With `w_ready` held 1, words 0..DEPTH-1 appear on consecutive cycles.
- `done` pulses the cycle after the word-(DEPTH-1) transfer. A full pass is DEPTH+2 cycles from E0 to `done`.
- Backpressure: at most 2 buffered words plus 0 in flight are outstanding. No word is lost or duplicated when `w_ready` drops.
- After `w_ready` rises, transfers resume the same cycle from the buffered head.
- DEPTH=1 is legal: `w_last`=1 on the first word.

## Test plan
- Preload mem[i]=16'h1000+i, pulse `start`, `w_ready`=1 → `w_valid` rises 2 cycles after E0. Data 1000..1009 arrives on 10 consecutive cycles, `w_idx` 0..9, `w_last` only on 1009, then a single `done` pulse with `busy` falling.
- Same preload, `w_ready` low for 5 cycles after the first valid → `w_data`=1000 held stable and `sram_addr` stops advancing at 1. The full in-order sequence completes after release.
- Random `w_ready` (50%) → all 10 words arrive in order, no duplicates, and `done` pulses exactly once.
- `start` pulsed again at word 4 → ignored. The stream stays in order, `busy` stays 1, and there is exactly one `done`.
- `rst` asserted asynchronously after word 5 → all outputs go to their reset values immediately and there is no `done`. A new `start` restreams from word 0.
- `start` held high across `done` → a second full pass of 1000..1009 begins; `sram_we` is 0 throughout every test.
